// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader
//  Purpose  : Loads a CPU program into instruction memory from a UART byte
//             stream. A rising edge on FLASH_ENABLE_in opens a load. Bytes
//             are packed little-endian into 32-bit words. Each word is
//             written to consecutive word addresses. The load ends at
//             STOP_WORD, which is never written, or when memory is full.
//  Ports    : CLK_100MHz_in   - sole clock, rising edge
//             RST_in          - synchronous active-high reset
//             FLASH_ENABLE_in - button level; rising edge starts/restarts
//             RX_DATA_in      - received byte, valid with RX_VALID_in
//             RX_VALID_in     - one-cycle strobe per received byte
//             MEM_WE_out      - one-cycle instruction-memory write strobe
//             MEM_ADDR_out    - word address of the write
//             MEM_DATA_out    - word being written
//             FLASHING_out    - high while loading (holds CPU in reset)
//             DONE_out        - one-cycle pulse at the end of a load
//             WORD_COUNT_out  - words written in the current/last load
//             OVERFLOW_out    - sticky: a word arrived with memory full
//  Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
   parameter int          ADDR_W         = 8,
   parameter logic [31:0] STOP_WORD      = 32'hFFFF_FFFF,
   parameter int          TIMEOUT_CYCLES = 2_000_000
) (
   input  logic              CLK_100MHz_in,
   input  logic              RST_in,
   input  logic              FLASH_ENABLE_in,
   input  logic [7:0]        RX_DATA_in,
   input  logic              RX_VALID_in,
   output logic              MEM_WE_out,
   output logic [ADDR_W-1:0] MEM_ADDR_out,
   output logic [31:0]       MEM_DATA_out,
   output logic              FLASHING_out,
   output logic              DONE_out,
   output logic [ADDR_W:0]   WORD_COUNT_out,
   output logic              OVERFLOW_out
);

   // The gap counter only has to reach TIMEOUT_CYCLES-1.
   localparam int              c_GAP_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ADDR_W:0] c_MEM_WORDS = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_WRITE  = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   state_t              r_state;
   logic                r_flash_q;
   logic [1:0]          r_byte_idx;
   logic [23:0]         r_word;       // bytes 0..2; byte 3 is taken straight from RX
   logic [c_GAP_W-1:0]  r_gap;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W:0]     r_count;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [31:0]         r_mem_data;
   logic                r_flashing;
   logic                r_done;
   logic                r_overflow;

   logic                w_flash_rise;
   logic                w_restart;
   logic [31:0]         w_word;
   logic                w_mem_full;

   assign w_flash_rise = FLASH_ENABLE_in & ~r_flash_q;
   // FINISH is a single-cycle exit state; an edge there is not honoured.
   assign w_restart    = w_flash_rise && (r_state != S_FINISH);
   assign w_word       = {RX_DATA_in, r_word};
   assign w_mem_full   = (r_count == c_MEM_WORDS);

   always_ff @(posedge CLK_100MHz_in) begin
      if (RST_in) begin
         r_state    <= S_IDLE;
         r_flash_q  <= 1'b0;
         r_byte_idx <= 2'd0;
         r_word     <= 24'd0;
         r_gap      <= '0;
         r_addr     <= '0;
         r_count    <= '0;
         r_mem_we   <= 1'b0;
         r_mem_addr <= '0;
         r_mem_data <= 32'd0;
         r_flashing <= 1'b0;
         r_done     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_flash_q <= FLASH_ENABLE_in;
         r_mem_we  <= 1'b0;
         r_done    <= 1'b0;

         if (w_restart) begin
            // In WRITE the strobe is already on the outputs this cycle, so
            // that write completes before the counters are cleared.
            r_state    <= S_LOAD;
            r_flashing <= 1'b1;
            r_addr     <= '0;
            r_count    <= '0;
            r_byte_idx <= 2'd0;
            r_gap      <= '0;
            r_overflow <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_state <= S_IDLE;
               end

               S_LOAD: begin
                  if (RX_VALID_in) begin
                     r_gap <= '0;
                     case (r_byte_idx)
                        2'd0: r_word[7:0]   <= RX_DATA_in;
                        2'd1: r_word[15:8]  <= RX_DATA_in;
                        2'd2: r_word[23:16] <= RX_DATA_in;
                        default: r_word <= r_word;
                     endcase
                     if (r_byte_idx != 2'd3) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                     end else begin
                        r_byte_idx <= 2'd0;
                        if (w_word == STOP_WORD) begin
                           r_state <= S_FINISH;
                           r_done  <= 1'b1;
                        end else if (w_mem_full) begin
                           r_overflow <= 1'b1;
                           r_state    <= S_FINISH;
                           r_done     <= 1'b1;
                        end else begin
                           r_state    <= S_WRITE;
                           r_mem_we   <= 1'b1;
                           r_mem_addr <= r_addr;
                           r_mem_data <= w_word;
                        end
                     end
                  end else if (r_byte_idx != 2'd0) begin
                     // A stalled partial word is dropped; the load stays open.
                     if (r_gap == c_GAP_LAST) begin
                        r_byte_idx <= 2'd0;
                        r_gap      <= '0;
                     end else begin
                        r_gap <= r_gap + 1'b1;
                     end
                  end
               end

               S_WRITE: begin
                  r_addr  <= r_addr + 1'b1;
                  r_count <= r_count + 1'b1;
                  r_state <= S_LOAD;
                  // Byte index is always 0 here, so a byte arriving now
                  // opens the next word.
                  if (RX_VALID_in) begin
                     r_word[7:0] <= RX_DATA_in;
                     r_byte_idx  <= 2'd1;
                     r_gap       <= '0;
                  end
               end

               S_FINISH: begin
                  r_state    <= S_IDLE;
                  r_flashing <= 1'b0;
               end

               default: begin
                  r_state    <= S_IDLE;
                  r_flashing <= 1'b0;
               end
            endcase
         end
      end
   end

   assign MEM_WE_out     = r_mem_we;
   assign MEM_ADDR_out   = r_mem_addr;
   assign MEM_DATA_out   = r_mem_data;
   assign FLASHING_out   = r_flashing;
   assign DONE_out       = r_done;
   assign WORD_COUNT_out = r_count;
   assign OVERFLOW_out   = r_overflow;

endmodule
`default_nettype wire
